// File: rtl/spram_pkg.sv
// Shared types and parameter legality checks for the byte-enable single-port RAM
// and its clear engine.
package spram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic bit rdlat_ok(input int rdlat);
    return (rdlat >= 0) && (rdlat <= 2);
  endfunction

  function automatic bit rdw_mode_ok(input logic [23:0] mode);
    return (mode == "NEW") || (mode == "OLD");
  endfunction

endpackage

// File: rtl/spram_be_if.sv
// Access, clear-request and read-return signals of the byte-enable RAM.
// The master modport drives requests; the RAM itself sits on the slave modport.
interface spram_be_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
);
  logic                  en;
  logic                  we;
  logic [DWIDTH/8-1:0]   be;
  logic [AWIDTH-1:0]     addr;
  logic [DWIDTH-1:0]     data;
  logic [DWIDTH-1:0]     q;
  logic                  q_valid;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output en, we, be, addr, data, clr_req,
    input  q, q_valid, busy
  );

  modport slave (
    input  en, we, be, addr, data, clr_req,
    output q, q_valid, busy
  );
endinterface

// File: rtl/spram_be_clr.sv
// Clear engine: walks every address once, owning the write port while it does so.
// clr_sel doubles as busy and as the write-port mux select in the parent.
module spram_be_clr
  import spram_pkg::*;
#(
  parameter int AWIDTH         = 8,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_sel,
  output logic [AWIDTH-1:0] clr_addr
);

  clr_state_e        state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              start_q, start_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req || start_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= START_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign clr_sel  = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/spram_be.sv
// Single-port RAM with byte enables, 0/1/2-cycle read latency, selectable
// read-during-write result and a whole-array clear engine.
module spram_be
  import spram_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter int                AWIDTH       = 8,
  parameter int                RDLAT        = 1,
  parameter                    RDW_MODE     = "NEW",
  parameter                    INIT_FILE    = "",
  parameter logic [DWIDTH-1:0] CLR_VAL      = '0,
  parameter                    CLR_ON_RESET = "N"
) (
  input logic       clk,
  input logic       rst_n,
  spram_be_if.slave bus
);

  localparam int DEPTH   = 1 << AWIDTH;
  localparam int NBYTES  = DWIDTH / 8;
  localparam bit RDW_NEW = (RDW_MODE == "NEW");

  if (DWIDTH % 8 != 0) begin : g_bad_dwidth
    $error("spram_be: DWIDTH must be a multiple of 8");
  end
  if (!rdlat_ok(RDLAT)) begin : g_bad_rdlat
    $error("spram_be: RDLAT must be 0, 1 or 2");
  end
  if (!rdw_mode_ok(RDW_MODE)) begin : g_bad_rdw
    $error("spram_be: RDW_MODE must be NEW or OLD");
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic              clr_sel;
  logic [AWIDTH-1:0] clr_addr;
  logic              accepted;
  logic [NBYTES-1:0] wr_be;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [DWIDTH-1:0] rd_old;

  spram_be_clr #(
    .AWIDTH        (AWIDTH),
    .START_ON_RESET(CLR_ON_RESET == "Y")
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (bus.clr_req),
    .clr_sel (clr_sel),
    .clr_addr(clr_addr)
  );

  assign accepted = bus.en & ~clr_sel;
  assign bus.busy = clr_sel;

  // The clear engine owns the write port while active; user accesses are dropped.
  always_comb begin
    wr_be   = '0;
    wr_addr = bus.addr;
    wr_data = bus.data;
    if (clr_sel) begin
      wr_be   = '1;
      wr_addr = clr_addr;
      wr_data = CLR_VAL;
    end else if (accepted && bus.we) begin
      wr_be = bus.be;
    end
  end

  // NOTE: the storage array has no reset; rst_n never touches its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign rd_old = mem_q[bus.addr];

  if (RDLAT == 0) begin : g_lat0
    assign bus.q       = rst_n ? rd_old : '0;
    assign bus.q_valid = rst_n & accepted;
  end else begin : g_lat12
    logic [DWIDTH-1:0] rd_merged, rd_d, q1_d, q1_q;
    logic              v1_d, v1_q;

    always_comb begin
      rd_merged = rd_old;
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) rd_merged[8*i +: 8] = bus.data[8*i +: 8];
      end
      rd_d = (bus.we && RDW_NEW) ? rd_merged : rd_old;
      q1_d = accepted ? rd_d : q1_q;
      v1_d = accepted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q1_q <= '0;
        v1_q <= 1'b0;
      end else begin
        q1_q <= q1_d;
        v1_q <= v1_d;
      end
    end

    if (RDLAT == 2) begin : g_lat2
      logic [DWIDTH-1:0] q2_q;
      logic              v2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          q2_q <= q1_q;
          v2_q <= v1_q;
        end
      end

      assign bus.q       = q2_q;
      assign bus.q_valid = v2_q;
    end else begin : g_lat1
      assign bus.q       = q1_q;
      assign bus.q_valid = v1_q;
    end
  end

endmodule
